// File: rtl/ccu_mem_wb_tracker.sv
// rtl/ccu_mem_wb_tracker.sv - write-back hazard tracker gating AW/AR traffic into the CCU memory controller
module ccu_mem_wb_tracker #(
  parameter int AddrWidth  = 64,
  parameter int IdWidth    = 4,
  parameter int LineOffset = 6,
  parameter int NumEntries = 4,
  parameter int CntWidth   = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               aw_valid_i,
  output logic                               aw_ready_o,
  input  logic [AddrWidth-1:0]               aw_addr_i,
  input  logic [IdWidth-1:0]                 aw_id_i,
  input  logic                               aw_wb_i,
  output logic                               aw_valid_o,
  input  logic                               aw_ready_i,
  input  logic                               ar_valid_i,
  output logic                               ar_ready_o,
  input  logic [AddrWidth-1:0]               ar_addr_i,
  output logic                               ar_valid_o,
  input  logic                               ar_ready_i,
  input  logic                               b_valid_i,
  input  logic                               b_ready_i,
  input  logic [IdWidth-1:0]                 b_id_i,
  input  logic                               b_wb_i,
  output logic [$clog2(NumEntries+1)-1:0]    pending_o,
  output logic [CntWidth-1:0]                ar_stall_cnt_o
);

  localparam int LineWidth = AddrWidth - LineOffset;
  localparam int PendWidth = $clog2(NumEntries + 1);
  localparam int IdxWidth  = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  logic [NumEntries-1:0] valid_q, valid_d;
  logic [LineWidth-1:0]  line_q [NumEntries];
  logic [LineWidth-1:0]  line_d [NumEntries];
  logic [IdWidth-1:0]    id_q   [NumEntries];
  logic [IdWidth-1:0]    id_d   [NumEntries];
  logic                  aw_lock_q, aw_lock_d;
  logic                  ar_lock_q, ar_lock_d;
  logic [CntWidth-1:0]   stall_cnt_q, stall_cnt_d;

  logic [LineWidth-1:0]  aw_line, ar_line;
  logic                  full, aw_id_hit, ar_line_hit;
  logic [NumEntries-1:0] b_match;
  logic [IdxWidth-1:0]   alloc_idx;
  logic                  alloc_found;
  logic                  aw_block, aw_fire, alloc;
  logic                  ar_hazard, ar_block, ar_fire;
  logic                  b_free;
  logic [PendWidth-1:0]  pend_cnt;
  logic                  unused_addr_bits;

  assign aw_line = aw_addr_i[AddrWidth-1:LineOffset];
  assign ar_line = ar_addr_i[AddrWidth-1:LineOffset];
  assign unused_addr_bits = ^{aw_addr_i[LineOffset-1:0], ar_addr_i[LineOffset-1:0]};

  always_comb begin
    full        = &valid_q;
    aw_id_hit   = 1'b0;
    ar_line_hit = 1'b0;
    b_match     = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    pend_cnt    = '0;
    for (int i = 0; i < NumEntries; i++) begin
      aw_id_hit   = aw_id_hit   | (valid_q[i] && (id_q[i] == aw_id_i));
      ar_line_hit = ar_line_hit | (valid_q[i] && (line_q[i] == ar_line));
      b_match[i]  = valid_q[i] && (id_q[i] == b_id_i);
      pend_cnt    = pend_cnt + PendWidth'(valid_q[i]);
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IdxWidth'(i);
        alloc_found = 1'b1;
      end
    end
  end

  // Once an AW has been offered downstream it stays offered, whatever the table does meanwhile.
  assign aw_block   = aw_wb_i & ~aw_lock_q & (full | aw_id_hit);
  assign aw_valid_o = aw_valid_i & ~aw_block;
  assign aw_ready_o = aw_ready_i & ~aw_block;
  assign aw_fire    = aw_valid_o & aw_ready_i;
  assign alloc      = aw_fire & aw_wb_i;

  // The same-cycle WB compare closes the window before the new entry becomes visible.
  assign ar_hazard  = ar_valid_i & (ar_line_hit | (alloc & (aw_line == ar_line)));
  assign ar_block   = ar_hazard & ~ar_lock_q;
  assign ar_valid_o = ar_valid_i & ~ar_block;
  assign ar_ready_o = ar_ready_i & ~ar_block;
  assign ar_fire    = ar_valid_o & ar_ready_i;

  assign b_free = b_valid_i & b_ready_i & b_wb_i;

  always_comb begin
    valid_d = valid_q;
    line_d  = line_q;
    id_d    = id_q;
    if (b_free) begin
      valid_d = valid_d & ~b_match;
    end
    if (alloc) begin
      valid_d[alloc_idx] = 1'b1;
      line_d[alloc_idx]  = aw_line;
      id_d[alloc_idx]    = aw_id_i;
    end
  end

  always_comb begin
    aw_lock_d = aw_lock_q;
    if (aw_fire) begin
      aw_lock_d = 1'b0;
    end else if (aw_valid_o) begin
      aw_lock_d = 1'b1;
    end
    ar_lock_d = ar_lock_q;
    if (ar_fire) begin
      ar_lock_d = 1'b0;
    end else if (ar_valid_o) begin
      ar_lock_d = 1'b1;
    end
    stall_cnt_d = stall_cnt_q;
    if (ar_block && (stall_cnt_q != {CntWidth{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      aw_lock_q   <= 1'b0;
      ar_lock_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      aw_lock_q   <= aw_lock_d;
      ar_lock_q   <= ar_lock_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    line_q <= line_d;
    id_q   <= id_d;
  end

  assign pending_o      = pend_cnt;
  assign ar_stall_cnt_o = stall_cnt_q;

  logic dup_id;
  always_comb begin
    dup_id = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      for (int j = i + 1; j < NumEntries; j++) begin
        if (valid_q[i] && valid_q[j] && (id_q[i] == id_q[j])) begin
          dup_id = 1'b1;
        end
      end
    end
  end

  a_no_alloc_full: assert property (@(posedge clk_i) disable iff (rst_i) !(alloc && full));
  a_unique_ids:    assert property (@(posedge clk_i) disable iff (rst_i) !dup_id);
  a_b_matches:     assert property (@(posedge clk_i) disable iff (rst_i) !(b_free && (b_match == '0)));

endmodule

// File: tb/tb_ccu_mem_wb_tracker.sv
// tb/tb_ccu_mem_wb_tracker.sv - scoreboard bench for ccu_mem_wb_tracker
module tb_ccu_mem_wb_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        aw_valid_i, aw_ready_o, aw_wb_i, aw_valid_o, aw_ready_i;
  logic [63:0] aw_addr_i;
  logic [3:0]  aw_id_i;
  logic        ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic [63:0] ar_addr_i;
  logic        b_valid_i, b_ready_i, b_wb_i;
  logic [3:0]  b_id_i;
  logic [2:0]  pending_o;
  logic [15:0] ar_stall_cnt_o;

  ccu_mem_wb_tracker dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_id_i(aw_id_i), .aw_wb_i(aw_wb_i), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i), .b_wb_i(b_wb_i),
    .pending_o(pending_o), .ar_stall_cnt_o(ar_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    int          cyc;
  } exp_t;

  exp_t exp_aw[$];
  exp_t exp_ar[$];
  exp_t e_aw, e_ar;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_aw(input logic [63:0] a, input int c);
    exp_t e;
    e.addr = a;
    e.cyc  = c;
    exp_aw.push_back(e);
  endtask

  task automatic push_ar(input logic [63:0] a, input int c);
    exp_t e;
    e.addr = a;
    e.cyc  = c;
    exp_ar.push_back(e);
  endtask

  // Monitor: every downstream handshake must match the next expected transfer in address and cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (aw_valid_o && aw_ready_i) begin
        n_checks++;
        if (exp_aw.size() == 0) begin
          n_fail++;
          $display("FAIL aw_unexpected: got addr %0h at cycle %0d, required no transfer", aw_addr_i, cyc);
        end else begin
          e_aw = exp_aw.pop_front();
          if (aw_addr_i !== e_aw.addr || cyc != e_aw.cyc) begin
            n_fail++;
            $display("FAIL aw_xfer: got addr %0h cycle %0d, required addr %0h cycle %0d",
                     aw_addr_i, cyc, e_aw.addr, e_aw.cyc);
          end
        end
      end
      if (ar_valid_o && ar_ready_i) begin
        n_checks++;
        if (exp_ar.size() == 0) begin
          n_fail++;
          $display("FAIL ar_unexpected: got addr %0h at cycle %0d, required no transfer", ar_addr_i, cyc);
        end else begin
          e_ar = exp_ar.pop_front();
          if (ar_addr_i !== e_ar.addr || cyc != e_ar.cyc) begin
            n_fail++;
            $display("FAIL ar_xfer: got addr %0h cycle %0d, required addr %0h cycle %0d",
                     ar_addr_i, cyc, e_ar.addr, e_ar.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int free_ids[4];
    free_ids = '{0, 1, 3, 5};
    rst_i = 1'b1;
    aw_valid_i = 1'b0; aw_addr_i = '0; aw_id_i = '0; aw_wb_i = 1'b0; aw_ready_i = 1'b1;
    ar_valid_i = 1'b0; ar_addr_i = '0; ar_ready_i = 1'b1;
    b_valid_i = 1'b0; b_ready_i = 1'b1; b_id_i = '0; b_wb_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    #2;
    check("rst_pending", pending_o, 0);
    check("rst_stall_cnt", ar_stall_cnt_o, 0);
    check("rst_aw_valid", aw_valid_o, 0);
    check("rst_ar_valid", ar_valid_o, 0);
    check("rst_aw_ready", aw_ready_o, 1);
    check("rst_ar_ready", ar_ready_o, 1);

    // Non-WB AW and AR to the same line both pass untouched
    tick();
    aw_valid_i = 1'b1; aw_addr_i = 64'h1000; aw_id_i = 4'd2; aw_wb_i = 1'b0;
    ar_valid_i = 1'b1; ar_addr_i = 64'h1000;
    push_aw(64'h1000, cyc);
    push_ar(64'h1000, cyc);
    #2;
    check("t1_aw_fwd", aw_valid_o, 1);
    tick();
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    #2;
    check("t1_pending", pending_o, 0);

    // WB then AR to the same 64B line: stalled until the B frees it
    tick();
    aw_valid_i = 1'b1; aw_addr_i = 64'h2040; aw_id_i = 4'd1; aw_wb_i = 1'b1;
    push_aw(64'h2040, cyc);
    tick();
    aw_valid_i = 1'b0; aw_wb_i = 1'b0;
    ar_valid_i = 1'b1; ar_addr_i = 64'h2078;
    #2;
    check("t2_ar_held", ar_valid_o, 0);
    check("t2_ar_ready_held", ar_ready_o, 0);
    check("t2_pending_1", pending_o, 1);
    tick();
    #2;
    check("t2_ar_held2", ar_valid_o, 0);
    tick();
    b_valid_i = 1'b1; b_id_i = 4'd1;
    push_ar(64'h2078, cyc + 1);
    #2;
    check("t2_ar_held_free_cycle", ar_valid_o, 0);
    tick();
    b_valid_i = 1'b0;
    #2;
    check("t2_ar_released", ar_valid_o, 1);
    check("t2_pending_0", pending_o, 0);
    tick();
    ar_valid_i = 1'b0;
    #2;
    check("t2_stall_cnt", ar_stall_cnt_o, 3);

    // Fill the table, fifth WB held until B id 2, then lands in entry 2
    for (int i = 0; i < 4; i++) begin
      tick();
      aw_valid_i = 1'b1; aw_wb_i = 1'b1;
      aw_addr_i = 64'h10000 + 64'(i) * 64'h40; aw_id_i = 4'(i);
      push_aw(aw_addr_i, cyc);
    end
    tick();
    aw_addr_i = 64'h20000; aw_id_i = 4'd5;
    #2;
    check("t3_full_valid", aw_valid_o, 0);
    check("t3_full_ready", aw_ready_o, 0);
    check("t3_pending_4", pending_o, 4);
    tick();
    #2;
    check("t3_full_held2", aw_valid_o, 0);
    tick();
    b_valid_i = 1'b1; b_id_i = 4'd2;
    push_aw(64'h20000, cyc + 1);
    #2;
    check("t3_held_free_cycle", aw_valid_o, 0);
    tick();
    b_valid_i = 1'b0;
    #2;
    check("t3_aw_released", aw_valid_o, 1);
    tick();
    aw_valid_i = 1'b0; aw_wb_i = 1'b0;
    #2;
    check("t3_pending_still_4", pending_o, 4);
    check("t3_entry2_valid", dut.valid_q[2], 1);
    check("t3_entry2_id", dut.id_q[2], 5);
    ar_valid_i = 1'b1; ar_addr_i = 64'h20010;
    #1;
    check("t3_ar_hits_entry2", ar_valid_o, 0);
    tick();
    ar_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_valid_i = 1'b1; b_id_i = 4'(free_ids[i]);
      tick();
    end
    b_valid_i = 1'b0;
    #2;
    check("t3_drained", pending_o, 0);

    // Duplicate-ID WB held until the first one's B
    tick();
    aw_valid_i = 1'b1; aw_wb_i = 1'b1; aw_addr_i = 64'h5000; aw_id_i = 4'd1;
    push_aw(64'h5000, cyc);
    tick();
    aw_addr_i = 64'h5040;
    #2;
    check("t4_dup_held", aw_valid_o, 0);
    check("t4_pending_1", pending_o, 1);
    tick();
    #2;
    check("t4_dup_held2", aw_valid_o, 0);
    tick();
    b_valid_i = 1'b1; b_id_i = 4'd1;
    push_aw(64'h5040, cyc + 1);
    #2;
    check("t4_held_free_cycle", aw_valid_o, 0);
    tick();
    b_valid_i = 1'b0;
    #2;
    check("t4_aw_released", aw_valid_o, 1);
    tick();
    aw_valid_i = 1'b0; aw_wb_i = 1'b0;
    #2;
    check("t4_pending_1b", pending_o, 1);
    b_valid_i = 1'b1; b_id_i = 4'd1;
    tick();
    b_valid_i = 1'b0;
    #2;
    check("t4_drained", pending_o, 0);

    // Locked AR ignores a WB to its line that arrives while it waits
    tick();
    ar_valid_i = 1'b1; ar_addr_i = 64'h3000; ar_ready_i = 1'b0;
    #2;
    check("t5_ar_offered", ar_valid_o, 1);
    tick();
    #2;
    check("t5_ar_offered2", ar_valid_o, 1);
    tick();
    #2;
    check("t5_ar_offered3", ar_valid_o, 1);
    tick();
    aw_valid_i = 1'b1; aw_wb_i = 1'b1; aw_addr_i = 64'h3000; aw_id_i = 4'd7;
    push_aw(64'h3000, cyc);
    #2;
    check("t5_ar_lock_bypass", ar_valid_o, 1);
    tick();
    aw_valid_i = 1'b0; aw_wb_i = 1'b0; ar_ready_i = 1'b1;
    push_ar(64'h3000, cyc);
    #2;
    check("t5_ar_lock_entry", ar_valid_o, 1);
    check("t5_pending_1", pending_o, 1);
    tick();
    ar_valid_i = 1'b0;
    #2;
    check("t5_stall_unchanged", ar_stall_cnt_o, 4);
    b_valid_i = 1'b1; b_id_i = 4'd7;
    tick();
    b_valid_i = 1'b0;

    // Same-cycle WB/AR bypass stall, then reset mid-stall
    tick();
    aw_valid_i = 1'b1; aw_wb_i = 1'b1; aw_addr_i = 64'h4000; aw_id_i = 4'd8;
    ar_valid_i = 1'b1; ar_addr_i = 64'h4010;
    push_aw(64'h4000, cyc);
    #2;
    check("t6_bypass_stall", ar_valid_o, 0);
    tick();
    aw_valid_i = 1'b0; aw_wb_i = 1'b0;
    #2;
    check("t6_entry_stall", ar_valid_o, 0);
    check("t6_pending_1", pending_o, 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    push_ar(64'h4010, cyc);
    #2;
    check("t6_ar_after_rst", ar_valid_o, 1);
    check("t6_pending_rst", pending_o, 0);
    check("t6_stall_rst", ar_stall_cnt_o, 0);
    tick();
    ar_valid_i = 1'b0;
    tick();
    tick();

    check("aw_queue_empty", 64'(exp_aw.size()), 0);
    check("ar_queue_empty", 64'(exp_ar.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
